fifo_wptr_full: RTL and testbench
=================================

FIFO_WPTR_FULL -- requirements
Module: fifo_wptr_full

Purpose: write-side (source-domain) pointer and full-flag generator for the asynchronous FIFO. It produces the Gray-coded write pointer that the read domain brings in through its 2-FF synchronizer. It consumes the already-synchronized read pointer.

Interface
REQ-001 Parameter ADDR_WIDTH, default 3, SHALL set FIFO depth DEPTH = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
REQ-002 Parameter AF_LEVEL, default 6, SHALL set the occupancy at or above which walmost_full asserts; legal range 1..DEPTH.
REQ-003 clk  input  1  write-domain clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 winc  input  1  write request for the current cycle.
REQ-006 wq2_rptr  input  ADDR_WIDTH+1  Gray-coded read pointer, already synchronized into clk.
REQ-007 clr_ovf  input  1  synchronous clear of the overflow flag.
REQ-008 waddr  output  ADDR_WIDTH  RAM write address, equal to the low ADDR_WIDTH bits of the binary write pointer.
REQ-009 wptr  output  ADDR_WIDTH+1  registered Gray write pointer, sent to the read-domain synchronizer.
REQ-010 wfull  output  1  registered full flag.
REQ-011 walmost_full  output  1  registered almost-full flag.
REQ-012 wlevel  output  ADDR_WIDTH+1  registered occupancy estimate, range 0..DEPTH.
REQ-013 overflow  output  1  sticky flag indicating a write was attempted while full.

Function
REQ-014 The write is accepted (wen) when winc=1 and wfull=0; the RAM write enable is wen.
REQ-015 Next binary pointer wbin_nx SHALL be wbin + wen, modulo 2**(ADDR_WIDTH+1); wrap from all-ones to 0 SHALL occur with no special handling.
REQ-016 Next Gray pointer SHALL be wbin_nx ^ (wbin_nx >> 1); wbin and wptr SHALL register on the same edge.
REQ-017 wptr SHALL be driven directly from a flop, with no combinational logic after it, and SHALL change in at most one bit per cycle.
REQ-018 wfull_nx SHALL be 1 when wgray_nx equals wq2_rptr with its two MSBs inverted and its remaining bits equal.
REQ-019 wfull SHALL register wfull_nx each cycle. A read-pointer advance SHALL deassert wfull one cycle after wq2_rptr changes.
REQ-020 wlevel_nx SHALL be wbin_nx minus gray2bin(wq2_rptr), modulo 2**(ADDR_WIDTH+1), and SHALL be registered.
REQ-021 walmost_full SHALL register (wlevel_nx >= AF_LEVEL).
REQ-022 overflow SHALL set on any cycle with winc=1 and wfull=1.
REQ-023 overflow SHALL clear on clr_ovf=1; if set and clear occur in the same cycle, set SHALL win.
REQ-024 A rejected write (winc=1, wfull=1) SHALL leave wbin, wptr and waddr unchanged.
REQ-025 wfull and wlevel are conservative: they may lag a read by the synchronizer latency, but SHALL never under-report occupancy.

Reset
REQ-026 While rst_n=0, the following SHALL be 0 immediately, independent of clk: wbin, wptr, waddr, wfull, walmost_full, wlevel and overflow.
REQ-027 Reset SHALL take effect mid-operation, discarding any in-flight write.
REQ-028 The first accepted write SHALL occur on the first rising edge after rst_n rises.

Verification (ADDR_WIDTH=3, AF_LEVEL=6)
REQ-029 Reset: assert rst_n=0 mid-clock -> all outputs 0 before the next edge.
REQ-030 Fill: hold wq2_rptr=0000 and issue 8 winc pulses.
- After the 6th write: walmost_full=1.
- After the 8th write: wptr=1100, waddr=000, wlevel=8, wfull=1.
- A 9th winc: wptr stays 1100 and overflow=1.
REQ-031 Drain release: from full, set wq2_rptr=0001 -> one edge later wfull=0 and wlevel=7; the next winc gives wptr=1101 and wfull=1.
REQ-032 Wrap: run 20 writes with wq2_rptr tracking wptr delayed by 2 cycles.
- wbin wraps 1111->0000 and wptr goes 1000->0000.
- A checker asserts the Hamming distance between consecutive wptr values is <=1 on every cycle.
- wfull is never set while the level is below 8.
REQ-033 Overflow clear: when winc=1, wfull=1 and clr_ovf=1 occur together -> overflow=1. clr_ovf alone on the next cycle -> overflow=0.
REQ-034 Reset mid-fill: after 5 writes, pulse rst_n=0 -> wptr=0000 and wlevel=0; the subsequent write gives wptr=0001.

Source files
------------

// File: rtl/fifo_wptr_full.sv
// Write-side pointer and flag generator for an asynchronous FIFO.
// It produces the Gray write pointer for the read domain and the full, almost-full, level and overflow flags.
`timescale 1ns/1ps
module fifo_wptr_full #(
  parameter int ADDR_WIDTH = 3,
  parameter int AF_LEVEL   = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  winc,
  input  logic [ADDR_WIDTH:0]   wq2_rptr,
  input  logic                  clr_ovf,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr,
  output logic                  wfull,
  output logic                  walmost_full,
  output logic [ADDR_WIDTH:0]   wlevel,
  output logic                  overflow
);

  localparam int PW = ADDR_WIDTH + 1;
  // Full means the write pointer is one lap ahead of the read pointer.
  // In Gray code that is the read pointer with its top two bits inverted.
  localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wptr_q, wgray_d;
  logic [PW-1:0] wlevel_q, wlevel_d;
  logic [PW-1:0] rbin;
  logic          wfull_q, wfull_d;
  logic          walmost_full_q, walmost_full_d;
  logic          overflow_q, overflow_d;
  logic          wen;

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // NOTE: every signal gets a value on every path through always_comb, so no latch is inferred.
  always_comb begin
    wen            = winc & ~wfull_q;
    wbin_d         = wbin_q + {{(PW-1){1'b0}}, wen};
    wgray_d        = wbin_d ^ (wbin_d >> 1);
    rbin           = gray2bin(wq2_rptr);
    wlevel_d       = wbin_d - rbin;
    wfull_d        = (wgray_d == (wq2_rptr ^ FULL_MASK));
    walmost_full_d = (wlevel_d >= PW'(AF_LEVEL));
    // A write attempted while full sets the flag even if a clear arrives in the same cycle.
    overflow_d     = (winc & wfull_q) | (overflow_q & ~clr_ovf);
  end

  // NOTE: state registers use non-blocking assignments so all of them update together from the old values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbin_q         <= '0;
      wptr_q         <= '0;
      wlevel_q       <= '0;
      wfull_q        <= 1'b0;
      walmost_full_q <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      wbin_q         <= wbin_d;
      wptr_q         <= wgray_d;
      wlevel_q       <= wlevel_d;
      wfull_q        <= wfull_d;
      walmost_full_q <= walmost_full_d;
      overflow_q     <= overflow_d;
    end
  end

  // The pointer crosses clock domains, so it is taken straight from its flop.
  assign wptr         = wptr_q;
  assign waddr        = wbin_q[ADDR_WIDTH-1:0];
  assign wfull        = wfull_q;
  assign walmost_full = walmost_full_q;
  assign wlevel       = wlevel_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Self-checking bench for fifo_wptr_full (ADDR_WIDTH=3, AF_LEVEL=6).
// An occupancy model pushes the expected outputs when a cycle is driven, and each scenario pops and compares them.
`timescale 1ns/1ps
module tb_fifo_wptr_full;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       winc;
  logic [3:0] wq2_rptr;
  logic       clr_ovf;
  logic [2:0] waddr;
  logic [3:0] wptr;
  logic       wfull;
  logic       walmost_full;
  logic [3:0] wlevel;
  logic       overflow;

  typedef struct packed {
    logic [3:0] wptr;
    logic [2:0] waddr;
    logic       wfull;
    logic       walmost_full;
    logic [3:0] wlevel;
    logic       overflow;
  } obs_t;

  int   checks   = 0;
  int   failures = 0;
  obs_t exp_q[$];

  // Occupancy model state
  logic [3:0] m_wbin;
  logic       m_full;
  logic       m_ovf;

  fifo_wptr_full #(.ADDR_WIDTH(3), .AF_LEVEL(6)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .winc         (winc),
    .wq2_rptr     (wq2_rptr),
    .clr_ovf      (clr_ovf),
    .waddr        (waddr),
    .wptr         (wptr),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wlevel       (wlevel),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [3:0] g2b(input logic [3:0] g);
    return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
  endfunction

  function automatic obs_t sample();
    return {wptr, waddr, wfull, walmost_full, wlevel, overflow};
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("wptr=%b waddr=%b full=%b af=%b lvl=%0d ovf=%b",
                     o.wptr, o.waddr, o.wfull, o.walmost_full, o.wlevel, o.overflow);
  endfunction

  task automatic model_reset();
    m_wbin = '0;
    m_full = 1'b0;
    m_ovf  = 1'b0;
    exp_q.delete();
  endtask

  // Drive one cycle, push what the model says the outputs become, then sample 1 ns after the edge.
  task automatic step(input logic w, input logic [3:0] rp, input logic clr);
    logic [3:0] occ;
    obs_t       e;
    winc     = w;
    wq2_rptr = rp;
    clr_ovf  = clr;
    if (w && !m_full) m_wbin = m_wbin + 4'd1;
    occ = m_wbin - g2b(rp);
    if (w && m_full) m_ovf = 1'b1;
    else if (clr)    m_ovf = 1'b0;
    m_full = (occ == 4'd8);
    e.wptr         = m_wbin ^ (m_wbin >> 1);
    e.waddr        = m_wbin[2:0];
    e.wfull        = m_full;
    e.walmost_full = (occ >= 4'd6);
    e.wlevel       = occ;
    e.overflow     = m_ovf;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n   = 1'b0;
    winc    = 1'b0;
    clr_ovf = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    obs_t e, got;
    rst_n = 1'b0; winc = 1'b0; wq2_rptr = '0; clr_ovf = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (sample() !== '0) begin
      failures++; $display("FAIL reset_hold: got %s expected all zero", fmt(sample()));
    end
    rst_n = 1'b1;
    step(1'b1, 4'b0000, 1'b0);
    got = sample(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL first_write: got %s expected %s", fmt(got), fmt(e)); end
    checks++;
    if (wptr !== 4'b0001) begin failures++; $display("FAIL first_write_wptr: got %b expected 0001", wptr); end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 4'b0000, 1'b0);
      got = sample(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin failures++; $display("FAIL pre_reset_%0d: got %s expected %s", i, fmt(got), fmt(e)); end
    end
    // Assert reset between edges with a write pending.
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (sample() !== '0) begin
      failures++; $display("FAIL reset_async: got %s expected all zero", fmt(sample()));
    end
    model_reset();
    @(posedge clk);
    #1;
    checks++;
    if (sample() !== '0) begin
      failures++; $display("FAIL reset_discard: got %s expected all zero", fmt(sample()));
    end
    winc  = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    obs_t e, got;
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 4'b0000, 1'b0);
      got = sample(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin failures++; $display("FAIL fill_%0d: got %s expected %s", i, fmt(got), fmt(e)); end
      if (i == 5) begin
        checks++;
        if (walmost_full !== 1'b0) begin failures++; $display("FAIL fill_af_below: got %b expected 0", walmost_full); end
      end
      if (i == 6) begin
        checks++;
        if (walmost_full !== 1'b1) begin failures++; $display("FAIL fill_af_at: got %b expected 1", walmost_full); end
      end
    end
    checks++;
    if ({wptr, waddr, wlevel, wfull} !== {4'b1100, 3'b000, 4'd8, 1'b1}) begin
      failures++;
      $display("FAIL fill_full: got wptr=%b waddr=%b lvl=%0d full=%b expected wptr=1100 waddr=000 lvl=8 full=1",
               wptr, waddr, wlevel, wfull);
    end
    step(1'b1, 4'b0000, 1'b0);
    got = sample(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL fill_9th: got %s expected %s", fmt(got), fmt(e)); end
    checks++;
    if ({wptr, overflow} !== {4'b1100, 1'b1}) begin
      failures++; $display("FAIL fill_overflow: got wptr=%b ovf=%b expected wptr=1100 ovf=1", wptr, overflow);
    end
  endtask

  task automatic test_ovf_clear();
    obs_t e, got;
    step(1'b1, 4'b0000, 1'b1);
    got = sample(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL ovf_set_wins: got %s expected %s", fmt(got), fmt(e)); end
    checks++;
    if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set_wins_flag: got %b expected 1", overflow); end
    step(1'b0, 4'b0000, 1'b1);
    got = sample(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL ovf_clear: got %s expected %s", fmt(got), fmt(e)); end
    checks++;
    if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear_flag: got %b expected 0", overflow); end
    clr_ovf = 1'b0;
  endtask

  task automatic test_drain();
    obs_t e, got;
    step(1'b0, 4'b0001, 1'b0);
    got = sample(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL drain_release: got %s expected %s", fmt(got), fmt(e)); end
    checks++;
    if ({wfull, wlevel} !== {1'b0, 4'd7}) begin
      failures++; $display("FAIL drain_release_flags: got full=%b lvl=%0d expected full=0 lvl=7", wfull, wlevel);
    end
    step(1'b1, 4'b0001, 1'b0);
    got = sample(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL drain_refill: got %s expected %s", fmt(got), fmt(e)); end
    checks++;
    if ({wptr, wfull} !== {4'b1101, 1'b1}) begin
      failures++; $display("FAIL drain_refill_flags: got wptr=%b full=%b expected wptr=1101 full=1", wptr, wfull);
    end
    winc = 1'b0;
  endtask

  task automatic test_reset_midfill();
    obs_t e, got;
    apply_reset();
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 4'b0000, 1'b0);
      got = sample(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin failures++; $display("FAIL midfill_%0d: got %s expected %s", i, fmt(got), fmt(e)); end
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({wptr, wlevel} !== {4'b0000, 4'd0}) begin
      failures++; $display("FAIL midfill_reset: got wptr=%b lvl=%0d expected wptr=0000 lvl=0", wptr, wlevel);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 4'b0000, 1'b0);
    got = sample(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL midfill_after: got %s expected %s", fmt(got), fmt(e)); end
    checks++;
    if (wptr !== 4'b0001) begin failures++; $display("FAIL midfill_after_wptr: got %b expected 0001", wptr); end
    winc = 1'b0;
  endtask

  task automatic test_wrap();
    obs_t       e, got;
    logic [3:0] hist[$];
    logic [3:0] prev, rp;
    logic       saw_wrap;
    apply_reset();
    hist     = '{4'b0000, 4'b0000};
    prev     = 4'b0000;
    saw_wrap = 1'b0;
    for (int i = 0; i < 20; i++) begin
      rp = hist.pop_front();
      step(1'b1, rp, 1'b0);
      got = sample(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin failures++; $display("FAIL wrap_%0d: got %s expected %s", i, fmt(got), fmt(e)); end
      checks++;
      if ($countones(got.wptr ^ prev) > 1) begin
        failures++; $display("FAIL wrap_gray_step_%0d: got %b after %b expected at most one bit change", i, got.wptr, prev);
      end
      checks++;
      if (got.wfull && e.wlevel < 4'd8) begin
        failures++; $display("FAIL wrap_false_full_%0d: got full=1 expected 0 at level %0d", i, e.wlevel);
      end
      if (prev == 4'b1000 && got.wptr == 4'b0000) saw_wrap = 1'b1;
      prev = got.wptr;
      hist.push_back(e.wptr);
    end
    checks++;
    if (!saw_wrap) begin failures++; $display("FAIL wrap_seen: got no 1000->0000 transition expected one"); end
    winc = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_ovf_clear();
    test_drain();
    test_reset_midfill();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
